// File: rtl/mips_alu_top.sv
//------------------------------------------------------------------------------
// mips_alu_top
//
// 32-bit MIPS-style EX-stage ALU with integrated ALU-control decode.
// The 2-bit ALUOp class from the main controller selects add (lw/sw),
// subtract (beq), an R-type funct decode, or a reserved code that yields zero.
// The result is registered. Inputs sampled on one rising edge are visible on
// the outputs from that edge on, giving one op per cycle with one cycle of
// latency.
//
// Optional feature macro: MIPS_ALU_MULT_EN
//   defined   : funct 011000 (mult) / 011001 (multu) produce a 64-bit product
//               split across High/Low.
//   undefined : no multiplier is built, those funct codes fall into the
//               unsupported bucket, and High is held at zero.
//
// Ports:
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-high reset (priority over ops)
//   A             in   32  operand A (rs)
//   B             in   32  operand B (rt or sign-extended immediate)
//   ALUOp         in   2   controller opcode class
//   InstructionOp in   6   funct field, only decoded when ALUOp == 2'b10
//   High          out  32  product[63:32] for mult/multu, otherwise 0
//   Low           out  32  ALU result, or product[31:0] for mult/multu
//   ZeroFlag      out  1   1 when the registered {High, Low} is all zero
//------------------------------------------------------------------------------
module mips_alu_top #(
  parameter int WIDTH = 32  // fixed at 32; kept for documentation
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       InstructionOp,
  output logic [WIDTH-1:0] High,
  output logic [WIDTH-1:0] Low,
  output logic             ZeroFlag
);

  // ALUOp classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // R-type funct codes
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
`ifdef MIPS_ALU_MULT_EN
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
`endif

  // Signed less-than; both operands are reinterpreted as two's complement.
  function automatic logic [WIDTH-1:0] slt_f(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    if ($signed(a) < $signed(b)) begin
      slt_f = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      slt_f = {WIDTH{1'b0}};
    end
  endfunction

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] high_d, high_q;
  logic [WIDTH-1:0] low_d,  low_q;
  logic             zero_d, zero_q;

  // add/addu and sub/subu share one adder each: no overflow trap, so the
  // signed and unsigned variants are bit-identical modulo 2^32.
  assign sum_s  = A + B;
  assign diff_s = A - B;

`ifdef MIPS_ALU_MULT_EN
  logic [2*WIDTH-1:0] prod_signed_s;
  logic [2*WIDTH-1:0] prod_unsigned_s;

  // Sign/zero-extend to 64 bits first so a plain 64x64 multiply keeps the
  // correct low 64 bits for both signed and unsigned products.
  assign prod_signed_s   = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_unsigned_s = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
`endif

  // ALU-control decode and result selection for the next register value.
  always_comb begin
    high_d = {WIDTH{1'b0}};
    low_d  = {WIDTH{1'b0}};
    case (ALUOp)
      ALUOP_ADD: low_d = sum_s;
      ALUOP_SUB: low_d = diff_s;
      ALUOP_RTYPE: begin
        case (InstructionOp)
          FUNCT_AND:  low_d = A & B;
          FUNCT_OR:   low_d = A | B;
          FUNCT_ADD:  low_d = sum_s;
          FUNCT_ADDU: low_d = sum_s;
          FUNCT_SUB:  low_d = diff_s;
          FUNCT_SUBU: low_d = diff_s;
          FUNCT_SLT:  low_d = slt_f(A, B);
`ifdef MIPS_ALU_MULT_EN
          FUNCT_MULT: begin
            high_d = prod_signed_s[2*WIDTH-1:WIDTH];
            low_d  = prod_signed_s[WIDTH-1:0];
          end
          FUNCT_MULTU: begin
            high_d = prod_unsigned_s[2*WIDTH-1:WIDTH];
            low_d  = prod_unsigned_s[WIDTH-1:0];
          end
`endif
          default: begin
            high_d = {WIDTH{1'b0}};
            low_d  = {WIDTH{1'b0}};
          end
        endcase
      end
      default: begin  // 2'b11 reserved
        high_d = {WIDTH{1'b0}};
        low_d  = {WIDTH{1'b0}};
      end
    endcase
    // High is zero for every non-multiply op, so one test covers both cases.
    zero_d = (high_d == {WIDTH{1'b0}}) && (low_d == {WIDTH{1'b0}});
  end

  // Output registers; reset forces an all-zero result with ZeroFlag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_q <= {WIDTH{1'b0}};
      low_q  <= {WIDTH{1'b0}};
      zero_q <= 1'b1;
    end else begin
      high_q <= high_d;
      low_q  <= low_d;
      zero_q <= zero_d;
    end
  end

  assign High     = high_q;
  assign Low      = low_q;
  assign ZeroFlag = zero_q;

endmodule

// File: tb/tb_mips_alu_top.sv
//------------------------------------------------------------------------------
// tb_mips_alu_top
//
// Directed, table-driven bench for mips_alu_top. Each table entry carries the
// operands, opcode class, funct and hand-computed expected High/Low/ZeroFlag.
// Entries are applied back to back, one per clock, and each result is checked
// just after the edge that registers it. Hand-written sequences cover reset,
// reset priority over a live op, and recovery after reset.
//------------------------------------------------------------------------------
module tb_mips_alu_top;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] exp_high;
    logic [31:0] exp_low;
    logic        exp_zero;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] high;
  logic [31:0] low;
  logic        zero_flag;

  int checks;
  int failures;
  vec_t vecs[$];

  mips_alu_top #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .A            (a),
    .B            (b),
    .ALUOp        (aluop),
    .InstructionOp(funct),
    .High         (high),
    .Low          (low),
    .ZeroFlag     (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic [31:0] va, input logic [31:0] vb,
                         input logic [1:0] vop, input logic [5:0] vf,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic ez);
    vec_t v;
    v.a = va; v.b = vb; v.aluop = vop; v.funct = vf;
    v.exp_high = eh; v.exp_low = el; v.exp_zero = ez;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] eh,
                       input logic [31:0] el, input logic ez);
    checks = checks + 1;
    if (high !== eh || low !== el || zero_flag !== ez) begin
      failures = failures + 1;
      $display("FAIL %s: got High=%h Low=%h Zero=%b, expected High=%h Low=%h Zero=%b",
               name, high, low, zero_flag, eh, el, ez);
    end
  endtask

  // Drive on the falling edge, let the rising edge register, sample 1 after.
  task automatic apply(input logic r, input logic [31:0] va, input logic [31:0] vb,
                       input logic [1:0] vop, input logic [5:0] vf);
    @(negedge clk);
    rst = r; a = va; b = vb; aluop = vop; funct = vf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; a = 32'h0; b = 32'h0; aluop = 2'b00; funct = 6'b000000;

    // Table: {A, B, ALUOp, funct, High, Low, Zero}
    add_vec(32'h87654321, 32'h12345678, 2'b00, 6'b000000, 32'h0, 32'h99999999, 1'b0);
    add_vec(32'h87654321, 32'h12345678, 2'b01, 6'b000000, 32'h0, 32'h7530ECA9, 1'b0);
    add_vec(32'h87654321, 32'h12345678, 2'b10, 6'b100100, 32'h0, 32'h02244220, 1'b0);
    add_vec(32'h87654321, 32'h12345678, 2'b10, 6'b100101, 32'h0, 32'h97755779, 1'b0);
    add_vec(32'h87654321, 32'h12345678, 2'b10, 6'b100000, 32'h0, 32'h99999999, 1'b0);
    add_vec(32'h87654321, 32'h12345678, 2'b10, 6'b100001, 32'h0, 32'h99999999, 1'b0);
    add_vec(32'h87654321, 32'h12345678, 2'b10, 6'b100010, 32'h0, 32'h7530ECA9, 1'b0);
    add_vec(32'h87654321, 32'h12345678, 2'b10, 6'b100011, 32'h0, 32'h7530ECA9, 1'b0);
    add_vec(32'h87654321, 32'h12345678, 2'b10, 6'b101010, 32'h0, 32'h00000001, 1'b0);
    // reversed slt: positive is not below negative
    add_vec(32'h12345678, 32'h87654321, 2'b10, 6'b101010, 32'h0, 32'h00000000, 1'b1);
    add_vec(32'h12345678, 32'h12345678, 2'b01, 6'b000000, 32'h0, 32'h00000000, 1'b1);
    add_vec(32'h12345678, 32'h12345678, 2'b10, 6'b100010, 32'h0, 32'h00000000, 1'b1);
    add_vec(32'hFFFFFFFF, 32'h00000001, 2'b00, 6'b000000, 32'h0, 32'h00000000, 1'b1);
    add_vec(32'h80000000, 32'h00000000, 2'b10, 6'b101010, 32'h0, 32'h00000001, 1'b0);
    add_vec(32'h00000000, 32'h80000000, 2'b10, 6'b101010, 32'h0, 32'h00000000, 1'b1);
    add_vec(32'h87654321, 32'h12345678, 2'b10, 6'b000000, 32'h0, 32'h00000000, 1'b1);
    add_vec(32'h87654321, 32'h12345678, 2'b11, 6'b100000, 32'h0, 32'h00000000, 1'b1);
    // funct ignored outside ALUOp=10: slt funct under add class still adds
    add_vec(32'h00000005, 32'h00000003, 2'b00, 6'b101010, 32'h0, 32'h00000008, 1'b0);
    add_vec(32'h00000005, 32'h00000003, 2'b01, 6'b100100, 32'h0, 32'h00000002, 1'b0);
`ifdef MIPS_ALU_MULT_EN
    add_vec(32'hFFFFFFFF, 32'h00000002, 2'b10, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    add_vec(32'hFFFFFFFF, 32'h00000002, 2'b10, 6'b011001, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    add_vec(32'h00010000, 32'h00010000, 2'b10, 6'b011001, 32'h00000001, 32'h00000000, 1'b0);
    add_vec(32'h00000000, 32'h12345678, 2'b10, 6'b011000, 32'h00000000, 32'h00000000, 1'b1);
`else
    add_vec(32'hFFFFFFFF, 32'h00000002, 2'b10, 6'b011000, 32'h0, 32'h00000000, 1'b1);
    add_vec(32'hFFFFFFFF, 32'h00000002, 2'b10, 6'b011001, 32'h0, 32'h00000000, 1'b1);
`endif
    add_vec(32'h0000000F, 32'h000000F0, 2'b10, 6'b100101, 32'h0, 32'h000000FF, 1'b0);

    // Reset with non-trivial inputs present
    apply(1'b1, 32'h87654321, 32'h12345678, 2'b00, 6'b000000);
    check("reset_state", 32'h0, 32'h0, 1'b1);
    apply(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 6'b100101);
    check("reset_hold", 32'h0, 32'h0, 1'b1);

    // First op after reset release appears after exactly one edge
    apply(1'b0, 32'h00000001, 32'h00000002, 2'b00, 6'b000000);
    check("post_reset_first", 32'h0, 32'h00000003, 1'b0);

    // Back-to-back table, a new op every cycle
    for (int i = 0; i < vecs.size(); i++) begin
      apply(1'b0, vecs[i].a, vecs[i].b, vecs[i].aluop, vecs[i].funct);
      check($sformatf("vec%0d", i), vecs[i].exp_high, vecs[i].exp_low, vecs[i].exp_zero);
    end

    // Reset must win over a live op in the same cycle
    apply(1'b0, 32'h87654321, 32'h12345678, 2'b10, 6'b100101);
    check("pre_rst_op", 32'h0, 32'h97755779, 1'b0);
    apply(1'b1, 32'h87654321, 32'h12345678, 2'b10, 6'b100101);
    check("rst_priority", 32'h0, 32'h0, 1'b1);
    apply(1'b0, 32'h87654321, 32'h12345678, 2'b01, 6'b000000);
    check("rst_recover", 32'h0, 32'h7530ECA9, 1'b0);

    // Held inputs keep producing the same result
    apply(1'b0, 32'h87654321, 32'h12345678, 2'b01, 6'b000000);
    check("hold_inputs", 32'h0, 32'h7530ECA9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_alu_top.md
Name: mips_alu_top

Overview:
- 32-bit MIPS-style ALU with integrated ALU-control decode.
- Decodes the 2-bit ALUOp from the main controller and the 6-bit R-type funct field, and performs the selected operation on A and B.
- Outputs are registered: Low carries the 32-bit result, High the upper product word.
- Sits in the EX stage of the MIPS datapath; ZeroFlag feeds branch (beq) logic.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the parameter is fixed for documentation only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- A  input  32  operand A (rs)
- B  input  32  operand B (rt or sign-extended immediate)
- ALUOp  input  2  controller opcode class
- InstructionOp  input  6  funct field, used only when ALUOp=2'b10
- High  output  32  upper result word: product[63:32] for mult/multu, else 0
- Low  output  32  ALU result, or product[31:0] for mult/multu
- ZeroFlag  output  1  1 when the registered result is all zero

Behaviour:
- Single clock domain, clk; rst is synchronous and active-high.
- rst=1 at a rising edge: High=0, Low=0, ZeroFlag=1. rst has priority over any operation in the same cycle.
- Latency: A, B, ALUOp and InstructionOp are sampled every rising edge. High, Low and ZeroFlag update on that same edge, so they are valid one cycle after the inputs. No handshake; fully pipelined at 1 op/cycle.
- ALUOp decode:
  - 2'b00: add (lw/sw address).
  - 2'b01: subtract A-B (beq).
  - 2'b10: decode InstructionOp.
  - 2'b11: reserved; result 0.
- Funct decode (ALUOp=2'b10):
  - 100100 AND
  - 100101 OR
  - 100000 add
  - 100001 addu
  - 100010 sub
  - 100011 subu
  - 101010 slt: signed compare, Low=32'h1 if $signed(A)<$signed(B), else 0
  - 011000 mult (signed 64-bit product)
  - 011001 multu (unsigned 64-bit product)
  - any other funct: High=0, Low=0.
- Arithmetic: add/addu produce identical modulo-2^32 results, as do sub/subu. No overflow trap and no overflow output. InstructionOp is ignored when ALUOp≠2'b10.
- High=0 for every non-multiply operation.
- ZeroFlag:
  - non-multiply ops: (next Low==0)
  - mult/multu: ({next High, next Low}==0)
  - ZeroFlag is registered alongside Low/High.
- Boundary behaviour:
  - Wrap-around on 0xFFFFFFFF+1 gives Low=0, ZeroFlag=1.
  - slt with A=0x80000000, B=0 gives 1.
  - A==B on sub gives ZeroFlag=1.
- Datapath (add/sub, logic, slt, multiply) is combinational between the input sampling and the output registers.

Optional Feature:
- MIPS_ALU_MULT_EN.
- Defined: funct 011000/011001 perform mult/multu as specified.
- Undefined: no multiplier is synthesised. Those funct codes are treated as unsupported (High=0, Low=0, ZeroFlag=1), and High is constant 0.

Test Plan:
- rst=1 for one edge with any inputs -> High=0, Low=0, ZeroFlag=1; then rst=0 and outputs follow the inputs next edge.
- A=0x87654321, B=0x12345678, ALUOp=00 -> Low=0x99999999, ZeroFlag=0. ALUOp=01 -> Low=0x7530ECA9.
- Same operands, ALUOp=10:
  - funct 100100 -> 0x02244220
  - funct 100101 -> 0x97755779
  - funct 100000/100001 -> 0x99999999
  - funct 100010/100011 -> 0x7530ECA9
  - funct 101010 -> 0x00000001
  - High=0 throughout.
- A=B=0x12345678, ALUOp=01 -> Low=0, ZeroFlag=1. A=0xFFFFFFFF, B=1, ALUOp=00 -> Low=0, ZeroFlag=1.
- With MIPS_ALU_MULT_EN, A=0xFFFFFFFF, B=2:
  - funct 011000 -> High=0xFFFFFFFF, Low=0xFFFFFFFE
  - funct 011001 -> High=0x00000001, Low=0xFFFFFFFE
  - Without the macro, both -> High=0, Low=0, ZeroFlag=1.
- Unsupported funct 000000 under ALUOp=10, and ALUOp=11 -> Low=0, High=0, ZeroFlag=1. Back-to-back op changes each cycle produce matching results with exactly 1-cycle latency.
